// File: rtl/rf_write_arbiter_if.sv
// Register-file write-arbiter bus: writeback request, secondary result handshake,
// decode-stage pending query and the regfile write port.
interface rf_write_arbiter_if;
   logic        pri_valid;
   logic [4:0]  pri_rd;
   logic [31:0] pri_data;
   logic        pri_stall;
   logic        sec_valid;
   logic        sec_ready;
   logic [4:0]  sec_rd;
   logic [31:0] sec_data;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic        pend_rs1;
   logic        pend_rs2;
   logic        rf_we;
   logic [4:0]  rf_a3;
   logic [31:0] rf_wd;

   modport master (
      output pri_valid, pri_rd, pri_data, sec_valid, sec_rd, sec_data, rs1, rs2,
      input  pri_stall, sec_ready, pend_rs1, pend_rs2, rf_we, rf_a3, rf_wd
   );

   modport slave (
      input  pri_valid, pri_rd, pri_data, sec_valid, sec_rd, sec_data, rs1, rs2,
      output pri_stall, sec_ready, pend_rs1, pend_rs2, rf_we, rf_a3, rf_wd
   );
endinterface

// File: rtl/rf_write_arbiter.sv
// Shares the regfile write port between writeback (primary) and a FIFO-buffered secondary path,
// with starvation-forced grants. Optional grant statistics are enabled by defining RFARB_STATS_EN.
module rf_write_arbiter #(
   parameter int DEPTH      = 4,
   parameter int STARVE_MAX = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   rf_write_arbiter_if.slave        bus,
   output logic [31:0]              stat_sec_grants,
   output logic [31:0]              stat_forced
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

   typedef enum logic [1:0] {
      SEL_IDLE = 2'd0,
      SEL_PRI  = 2'd1,
      SEL_SEC  = 2'd2
   } sel_e;

   logic [4:0]    rd_mem_r   [DEPTH];
   logic [31:0]   data_mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic [SW-1:0] starve_r;

   sel_e          sel_s;
   logic          nonempty_s;
   logic          full_s;
   logic          push_s;
   logic          pop_s;
   logic          sec_ready_s;
   logic          pri_stall_s;
   logic          rf_we_s;
   logic [4:0]    rf_a3_s;
   logic [31:0]   rf_wd_s;
   logic          pend_rs1_s;
   logic          pend_rs2_s;

   // Entry at slot is live when its distance from the read pointer is below the fill count.
   function automatic logic slot_live(input logic [PW-1:0] slot, input logic [PW-1:0] rptr,
                                      input logic [CW-1:0] cnt);
      logic [PW-1:0] off;
      off = slot - rptr;
      return ({1'b0, off} < cnt);
   endfunction

   assign nonempty_s  = (count_r != {CW{1'b0}});
   assign full_s      = (count_r == DEPTH_C);
   // Ready comes from the registered count only, so a same-cycle pop never admits a push into a full FIFO.
   assign sec_ready_s = reset & ~full_s;
   assign push_s      = bus.sec_valid & sec_ready_s & (bus.sec_rd != 5'd0);
   assign pop_s       = (sel_s == SEL_SEC);
   assign pri_stall_s = bus.pri_valid & (sel_s == SEL_SEC);

   // Write-port owner for this cycle.
   always_comb begin
      sel_s = SEL_IDLE;
      if (!reset) begin
         sel_s = SEL_IDLE;
      end else if (nonempty_s && (!bus.pri_valid || starve_r == STARVE_C)) begin
         sel_s = SEL_SEC;
      end else if (bus.pri_valid) begin
         sel_s = SEL_PRI;
      end else begin
         sel_s = SEL_IDLE;
      end
   end

   // Drive the regfile write port from the selected source; x0 writes are swallowed.
   always_comb begin
      rf_we_s = 1'b0;
      rf_a3_s = 5'd0;
      rf_wd_s = 32'd0;
      case (sel_s)
         SEL_PRI: begin
            rf_we_s = (bus.pri_rd != 5'd0);
            rf_a3_s = bus.pri_rd;
            rf_wd_s = bus.pri_data;
         end
         SEL_SEC: begin
            rf_we_s = 1'b1;
            rf_a3_s = rd_mem_r[rd_ptr_r];
            rf_wd_s = data_mem_r[rd_ptr_r];
         end
         default: begin
            rf_we_s = 1'b0;
            rf_a3_s = 5'd0;
            rf_wd_s = 32'd0;
         end
      endcase
   end

   // Pending flags: any live queued entry or an accepted push targeting the source register.
   always_comb begin
      pend_rs1_s = 1'b0;
      pend_rs2_s = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         pend_rs1_s = pend_rs1_s | (slot_live(PW'(i), rd_ptr_r, count_r) && rd_mem_r[i] == bus.rs1);
         pend_rs2_s = pend_rs2_s | (slot_live(PW'(i), rd_ptr_r, count_r) && rd_mem_r[i] == bus.rs2);
      end
      pend_rs1_s = pend_rs1_s | (push_s && bus.sec_rd == bus.rs1);
      pend_rs2_s = pend_rs2_s | (push_s && bus.sec_rd == bus.rs2);
      pend_rs1_s = pend_rs1_s & reset & (bus.rs1 != 5'd0);
      pend_rs2_s = pend_rs2_s & reset & (bus.rs2 != 5'd0);
   end

   assign bus.rf_we     = rf_we_s;
   assign bus.rf_a3     = rf_a3_s;
   assign bus.rf_wd     = rf_wd_s;
   assign bus.pri_stall = pri_stall_s;
   assign bus.sec_ready = sec_ready_s;
   assign bus.pend_rs1  = pend_rs1_s;
   assign bus.pend_rs2  = pend_rs2_s;

   // FIFO storage; contents need no reset because liveness is tracked by count.
   always_ff @(posedge clk) begin
      if (push_s) begin
         rd_mem_r[wr_ptr_r]   <= bus.sec_rd;
         data_mem_r[wr_ptr_r] <= bus.sec_data;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_r <= {PW{1'b0}};
         rd_ptr_r <= {PW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         count_r <= count_r + {{(CW-1){1'b0}}, push_s} - {{(CW-1){1'b0}}, pop_s};
      end
   end

   // Head age: counts cycles the head waits, saturating at the forcing threshold.
   always_ff @(posedge clk) begin
      if (!reset) begin
         starve_r <= {SW{1'b0}};
      end else if (pop_s || !nonempty_s) begin
         starve_r <= {SW{1'b0}};
      end else if (starve_r != STARVE_C) begin
         starve_r <= starve_r + SW'(1);
      end else begin
         starve_r <= starve_r;
      end
   end

`ifdef RFARB_STATS_EN
   logic [31:0] stat_sec_r;
   logic [31:0] stat_forced_r;

   // Wrapping grant statistics.
   always_ff @(posedge clk) begin
      if (!reset) begin
         stat_sec_r    <= 32'd0;
         stat_forced_r <= 32'd0;
      end else begin
         if (pop_s) begin
            stat_sec_r <= stat_sec_r + 32'd1;
         end
         if (pri_stall_s) begin
            stat_forced_r <= stat_forced_r + 32'd1;
         end
      end
   end

   assign stat_sec_grants = stat_sec_r;
   assign stat_forced     = stat_forced_r;
`else
   assign stat_sec_grants = 32'd0;
   assign stat_forced     = 32'd0;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed self-checking bench for rf_write_arbiter: reset, primary/secondary writes,
// starvation forcing, FIFO fill/drain with wrap, x0 handling and back-to-back push/pop.
module tb_rf_write_arbiter;
   localparam int DEPTH      = 4;
   localparam int STARVE_MAX = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] stat_sec_grants;
   logic [31:0] stat_forced;
   int          checks = 0;
   int          errors = 0;

   rf_write_arbiter_if bus();

   rf_write_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
      .clk             (clk),
      .reset           (reset),
      .bus             (bus),
      .stat_sec_grants (stat_sec_grants),
      .stat_forced     (stat_forced)
   );

   always #5 clk = ~clk;

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.pri_valid = 1'b0; bus.pri_rd = 5'd0; bus.pri_data = 32'd0;
      bus.sec_valid = 1'b0; bus.sec_rd = 5'd0; bus.sec_data = 32'd0;
      bus.rs1 = 5'd0; bus.rs2 = 5'd0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b0;
      next_cycle();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      idle_inputs();
      reset = 1'b0;
      bus.pri_valid = 1'b1; bus.pri_rd = 5'd3; bus.pri_data = 32'h1234_5678;
      bus.sec_valid = 1'b1; bus.sec_rd = 5'd9; bus.sec_data = 32'h0000_0099;
      bus.rs1 = 5'd9; bus.rs2 = 5'd3;
      for (int c = 0; c < 2; c++) begin
         @(posedge clk); #2;
         if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b exp 0", bus.rf_we); end checks++;
         if (bus.sec_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0", bus.sec_ready); end checks++;
         if (bus.pend_rs1 !== 1'b0 || bus.pend_rs2 !== 1'b0) begin errors++; $display("FAIL reset_pend: got %b%b exp 00", bus.pend_rs1, bus.pend_rs2); end checks++;
         if (bus.pri_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b exp 0", bus.pri_stall); end checks++;
         if (bus.rf_a3 !== 5'd0 || bus.rf_wd !== 32'd0) begin errors++; $display("FAIL reset_port: got a3=%0d wd=%h exp 0/0", bus.rf_a3, bus.rf_wd); end checks++;
      end
      @(posedge clk); #1;
      reset = 1'b1;
      idle_inputs();
      bus.rs1 = 5'd9;
      #2;
      if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL post_reset_empty: got we=%b exp 0", bus.rf_we); end checks++;
      if (bus.sec_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready: got %b exp 1", bus.sec_ready); end checks++;
      if (bus.pend_rs1 !== 1'b0) begin errors++; $display("FAIL post_reset_pend: got %b exp 0", bus.pend_rs1); end checks++;
      next_cycle();
   endtask

   task automatic test_pri_write();
      bus.pri_valid = 1'b1; bus.pri_rd = 5'd5; bus.pri_data = 32'hDEAD_BEEF;
      #2;
      if (bus.rf_we !== 1'b1) begin errors++; $display("FAIL pri_we: got %b exp 1", bus.rf_we); end checks++;
      if (bus.rf_a3 !== 5'd5) begin errors++; $display("FAIL pri_a3: got %0d exp 5", bus.rf_a3); end checks++;
      if (bus.rf_wd !== 32'hDEAD_BEEF) begin errors++; $display("FAIL pri_wd: got %h exp deadbeef", bus.rf_wd); end checks++;
      if (bus.pri_stall !== 1'b0) begin errors++; $display("FAIL pri_stall: got %b exp 0", bus.pri_stall); end checks++;
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_sec_push();
      bus.sec_valid = 1'b1; bus.sec_rd = 5'd7; bus.sec_data = 32'h0000_0011; bus.rs1 = 5'd7;
      #2;
      if (bus.sec_ready !== 1'b1) begin errors++; $display("FAIL sec_push_ready: got %b exp 1", bus.sec_ready); end checks++;
      if (bus.pend_rs1 !== 1'b1) begin errors++; $display("FAIL sec_pend_push: got %b exp 1", bus.pend_rs1); end checks++;
      if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL sec_push_we: got %b exp 0", bus.rf_we); end checks++;
      next_cycle();
      bus.sec_valid = 1'b0;
      #2;
      if (bus.rf_we !== 1'b1 || bus.rf_a3 !== 5'd7 || bus.rf_wd !== 32'h11) begin
         errors++; $display("FAIL sec_write: got we=%b a3=%0d wd=%h exp 1/7/11", bus.rf_we, bus.rf_a3, bus.rf_wd);
      end checks++;
      if (bus.pend_rs1 !== 1'b1) begin errors++; $display("FAIL sec_pend_write: got %b exp 1", bus.pend_rs1); end checks++;
      next_cycle();
      #2;
      if (bus.pend_rs1 !== 1'b0) begin errors++; $display("FAIL sec_pend_after: got %b exp 0", bus.pend_rs1); end checks++;
      if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL sec_after_we: got %b exp 0", bus.rf_we); end checks++;
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_starve();
      do_reset();
      bus.pri_valid = 1'b1; bus.pri_rd = 5'd10; bus.pri_data = 32'h0000_00A0;
      bus.sec_valid = 1'b1; bus.sec_rd = 5'd12; bus.sec_data = 32'h0000_0055;
      #2;
      if (bus.rf_a3 !== 5'd10 || bus.sec_ready !== 1'b1) begin
         errors++; $display("FAIL starve_push: got a3=%0d ready=%b exp 10/1", bus.rf_a3, bus.sec_ready);
      end checks++;
      next_cycle();
      bus.sec_valid = 1'b0;
      for (int i = 0; i < STARVE_MAX; i++) begin
         bus.pri_data = 32'h0000_00A1 + 32'(i);
         #2;
         if (bus.rf_we !== 1'b1 || bus.rf_a3 !== 5'd10 || bus.rf_wd !== 32'h0000_00A1 + 32'(i) || bus.pri_stall !== 1'b0) begin
            errors++; $display("FAIL starve_pri%0d: got we=%b a3=%0d wd=%h stall=%b exp 1/10/%h/0",
                               i, bus.rf_we, bus.rf_a3, bus.rf_wd, bus.pri_stall, 32'h0000_00A1 + 32'(i));
         end checks++;
         next_cycle();
      end
      bus.pri_data = 32'h0000_00B0;
      #2;
      if (bus.rf_we !== 1'b1 || bus.rf_a3 !== 5'd12 || bus.rf_wd !== 32'h55) begin
         errors++; $display("FAIL starve_forced: got we=%b a3=%0d wd=%h exp 1/12/55", bus.rf_we, bus.rf_a3, bus.rf_wd);
      end checks++;
      if (bus.pri_stall !== 1'b1) begin errors++; $display("FAIL starve_stall: got %b exp 1", bus.pri_stall); end checks++;
      next_cycle();
      #2;
      if (bus.rf_a3 !== 5'd10 || bus.rf_wd !== 32'h0000_00B0 || bus.pri_stall !== 1'b0) begin
         errors++; $display("FAIL starve_resume: got a3=%0d wd=%h stall=%b exp 10/b0/0", bus.rf_a3, bus.rf_wd, bus.pri_stall);
      end checks++;
`ifdef RFARB_STATS_EN
      if (stat_sec_grants !== 32'd1 || stat_forced !== 32'd1) begin
         errors++; $display("FAIL stats: got grants=%0d forced=%0d exp 1/1", stat_sec_grants, stat_forced);
      end checks++;
`else
      if (stat_sec_grants !== 32'd0 || stat_forced !== 32'd0) begin
         errors++; $display("FAIL stats_tied: got grants=%0d forced=%0d exp 0/0", stat_sec_grants, stat_forced);
      end checks++;
`endif
      next_cycle();
      idle_inputs();
   endtask

   task automatic test_fill_drain();
      bus.pri_valid = 1'b1; bus.pri_rd = 5'd20; bus.pri_data = 32'h0000_0020; bus.rs2 = 5'd3;
      for (int k = 1; k <= DEPTH; k++) begin
         bus.sec_valid = 1'b1; bus.sec_rd = 5'(k); bus.sec_data = 32'h0000_0100 + 32'(k);
         #2;
         if (bus.sec_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d: got %b exp 1", k, bus.sec_ready); end checks++;
         next_cycle();
      end
      bus.sec_rd = 5'd9; bus.sec_data = 32'h0000_0999;
      #2;
      if (bus.sec_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b exp 0", bus.sec_ready); end checks++;
      if (bus.pend_rs2 !== 1'b1) begin errors++; $display("FAIL full_pend: got %b exp 1", bus.pend_rs2); end checks++;
      if (bus.rf_a3 !== 5'd20) begin errors++; $display("FAIL full_pri: got a3=%0d exp 20", bus.rf_a3); end checks++;
      next_cycle();
      idle_inputs();
      for (int k = 1; k <= DEPTH; k++) begin
         #2;
         if (bus.rf_we !== 1'b1 || bus.rf_a3 !== 5'(k) || bus.rf_wd !== 32'h0000_0100 + 32'(k)) begin
            errors++; $display("FAIL drain%0d: got we=%b a3=%0d wd=%h exp 1/%0d/%h", k, bus.rf_we, bus.rf_a3, bus.rf_wd, k, 32'h100 + 32'(k));
         end checks++;
         if (k == 1 && bus.sec_ready !== 1'b0) begin errors++; $display("FAIL drain_ready_pop: got %b exp 0", bus.sec_ready); end
         if (k == 1) checks++;
         if (k == 2 && bus.sec_ready !== 1'b1) begin errors++; $display("FAIL drain_ready_after: got %b exp 1", bus.sec_ready); end
         if (k == 2) checks++;
         next_cycle();
      end
      #2;
      if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL drain_empty: got we=%b a3=%0d exp 0", bus.rf_we, bus.rf_a3); end checks++;
      next_cycle();
   endtask

   task automatic test_rd_zero();
      bus.pri_valid = 1'b1; bus.pri_rd = 5'd0; bus.pri_data = 32'hFFFF_FFFF;
      bus.sec_valid = 1'b1; bus.sec_rd = 5'd0; bus.sec_data = 32'h0000_0077;
      #2;
      if (bus.rf_we !== 1'b0 || bus.pri_stall !== 1'b0) begin
         errors++; $display("FAIL x0_write: got we=%b stall=%b exp 0/0", bus.rf_we, bus.pri_stall);
      end checks++;
      if (bus.sec_ready !== 1'b1) begin errors++; $display("FAIL x0_ready: got %b exp 1", bus.sec_ready); end checks++;
      next_cycle();
      idle_inputs();
      #2;
      if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL x0_not_queued: got we=%b a3=%0d exp 0", bus.rf_we, bus.rf_a3); end checks++;
      next_cycle();
   endtask

   task automatic test_back_to_back();
      bus.sec_valid = 1'b1; bus.sec_rd = 5'd2; bus.sec_data = 32'h0000_0002;
      #2;
      if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL b2b_first: got we=%b exp 0", bus.rf_we); end checks++;
      next_cycle();
      bus.sec_rd = 5'd3; bus.sec_data = 32'h0000_0003;
      #2;
      if (bus.rf_we !== 1'b1 || bus.rf_a3 !== 5'd2 || bus.sec_ready !== 1'b1) begin
         errors++; $display("FAIL b2b_pushpop: got we=%b a3=%0d ready=%b exp 1/2/1", bus.rf_we, bus.rf_a3, bus.sec_ready);
      end checks++;
      next_cycle();
      bus.sec_valid = 1'b0;
      #2;
      if (bus.rf_we !== 1'b1 || bus.rf_a3 !== 5'd3 || bus.rf_wd !== 32'h3) begin
         errors++; $display("FAIL b2b_second: got we=%b a3=%0d wd=%h exp 1/3/3", bus.rf_we, bus.rf_a3, bus.rf_wd);
      end checks++;
      next_cycle();
      #2;
      if (bus.rf_we !== 1'b0) begin errors++; $display("FAIL b2b_empty: got we=%b exp 0", bus.rf_we); end checks++;
      next_cycle();
   endtask

   initial begin
      test_reset();
      test_pri_write();
      test_sec_push();
      test_starve();
      test_fill_drain();
      test_rd_zero();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
